// File: rtl/riscv_mc_controller.sv
// Multicycle control FSM for the RV32I subset core.
// It sequences fetch, decode, memory, execute and writeback through the shared datapath.
// Control outputs are decoded from the current state and the instruction fields.
// The write enables, mem_req and illegal_instr are gated off while reset is high.
module riscv_mc_controller (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_write,
   output logic       adr_src,
   output logic       ir_write,
   output logic       pc_write,
   output logic       reg_write,
   output logic [1:0] result_src,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] imm_src,
   output logic [2:0] alu_ctrl,
   output logic       illegal_instr
);

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLL = 3'b100;
   localparam logic [2:0] ALU_SLT = 3'b101;
   localparam logic [2:0] ALU_XOR = 3'b110;

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
      S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL
   } state_t;

   state_t     state;
   state_t     state_nxt;
   logic [2:0] exec_alu;
   logic       exec_bad;

   // State register; reset returns to FETCH immediately
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_FETCH;
      else       state <= state_nxt;
   end

   // ALU operation for register and immediate arithmetic; shift right is unsupported
   always_comb begin
      exec_alu = ALU_ADD;
      exec_bad = 1'b0;
      case (funct3)
         3'b000:  exec_alu = (op == OP_RTYPE && funct7b5) ? ALU_SUB : ALU_ADD;
         3'b001:  exec_alu = ALU_SLL;
         3'b010,
         3'b011:  exec_alu = ALU_SLT;
         3'b100:  exec_alu = ALU_XOR;
         3'b101:  exec_bad = 1'b1;
         3'b110:  exec_alu = ALU_OR;
         default: exec_alu = ALU_AND;
      endcase
   end

   // Immediate format follows the opcode
   always_comb begin
      case (op)
         OP_STORE:  imm_src = 2'b01;
         OP_BRANCH: imm_src = 2'b10;
         OP_JAL:    imm_src = 2'b11;
         default:   imm_src = 2'b00;
      endcase
   end

   // Next-state and control decode, with enables masked during reset
   always_comb begin
      state_nxt     = state;
      mem_req       = 1'b0;
      mem_write     = 1'b0;
      adr_src       = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      reg_write     = 1'b0;
      result_src    = 2'b00;
      alu_src_a     = 2'b00;
      alu_src_b     = 2'b00;
      alu_ctrl      = ALU_ADD;
      illegal_instr = 1'b0;
      case (state)
         S_FETCH: begin
            mem_req    = 1'b1;
            alu_src_b  = 2'b10;
            result_src = 2'b10;
            ir_write   = mem_ready;
            pc_write   = mem_ready;
            if (mem_ready) state_nxt = S_DECODE;
         end
         S_DECODE: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b01;
            case (op)
               OP_LOAD, OP_STORE: state_nxt = S_MEMADR;
               OP_RTYPE:          state_nxt = S_EXECR;
               OP_ITYPE:          state_nxt = S_EXECI;
               OP_JAL:            state_nxt = S_JAL;
               OP_BRANCH: begin
                  if (funct3[2:1] == 2'b00) begin
                     state_nxt = S_BRANCH;
                  end else begin
                     illegal_instr = 1'b1;
                     state_nxt     = S_FETCH;
                  end
               end
               default: begin
                  illegal_instr = 1'b1;
                  state_nxt     = S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            state_nxt = op[5] ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            mem_req = 1'b1;
            adr_src = 1'b1;
            if (mem_ready) state_nxt = S_MEMWB;
         end
         S_MEMWB: begin
            result_src = 2'b01;
            reg_write  = 1'b1;
            state_nxt  = S_FETCH;
         end
         S_MEMWRITE: begin
            mem_req   = 1'b1;
            mem_write = 1'b1;
            adr_src   = 1'b1;
            if (mem_ready) state_nxt = S_FETCH;
         end
         S_EXECR, S_EXECI: begin
            alu_src_a = 2'b10;
            alu_src_b = (state == S_EXECI) ? 2'b01 : 2'b00;
            alu_ctrl  = exec_alu;
            if (exec_bad) begin
               illegal_instr = 1'b1;
               state_nxt     = S_FETCH;
            end else begin
               state_nxt = S_ALUWB;
            end
         end
         S_ALUWB: begin
            reg_write = 1'b1;
            state_nxt = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a = 2'b10;
            alu_ctrl  = ALU_SUB;
            pc_write  = zero ^ funct3[0];
            state_nxt = S_FETCH;
         end
         S_JAL: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b10;
            pc_write  = 1'b1;
            state_nxt = S_ALUWB;
         end
         default: state_nxt = S_FETCH;
      endcase
      if (reset) begin
         mem_req       = 1'b0;
         mem_write     = 1'b0;
         ir_write      = 1'b0;
         pc_write      = 1'b0;
         reg_write     = 1'b0;
         illegal_instr = 1'b0;
      end
   end

endmodule

// File: tb/tb_riscv_mc_controller.sv
// Self-checking bench for riscv_mc_controller: directed cases plus random instructions
// with random memory wait states, checked against an instruction-level latency/effect model.
module tb_riscv_mc_controller;

   localparam int unsigned MAXC = 64;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [6:0] op = 7'h00;
   logic [2:0] funct3 = 3'd0;
   logic       funct7b5 = 1'b0;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b0;
   logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, illegal_instr;
   logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
   logic [2:0] alu_ctrl;

   int errors = 0;
   int checks = 0;

   logic       rdy  [MAXC];
   logic       zv   [MAXC];
   logic       s_req[MAXC], s_mwr[MAXC], s_adr[MAXC], s_irw[MAXC];
   logic       s_pcw[MAXC], s_rgw[MAXC], s_ill[MAXC];
   logic [1:0] s_res[MAXC], s_sa[MAXC], s_sb[MAXC], s_imm[MAXC];
   logic [2:0] s_alu[MAXC];

   riscv_mc_controller dut (
      .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
      .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write),
      .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
      .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .imm_src(imm_src), .alu_ctrl(alu_ctrl), .illegal_instr(illegal_instr)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s (op=%02h f3=%0d): observed %0h expected %0h", tag, op, funct3, obs, exp);
      end
   endtask

   // Runs one instruction from FETCH with wf fetch waits and wd data waits; zmode 0/1 forces zero, 2 randomizes
   task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                            input int wf, input int wd, input int zmode);
      bit is_r, is_i, is_ld, is_st, is_br, is_jal, dec_ok, ex_bad, exp_rw;
      int fl, total, n_req, n_mwr, n_irw, n_pcw, n_rgw, n_ill, exp_pcw;
      logic [2:0] exp_alu;
      logic [1:0] exp_imm;
      is_r   = (o == 7'h33);
      is_i   = (o == 7'h13);
      is_ld  = (o == 7'h03);
      is_st  = (o == 7'h23);
      is_br  = (o == 7'h63);
      is_jal = (o == 7'h6F);
      dec_ok = is_r | is_i | is_ld | is_st | is_jal | (is_br && f3 <= 3'd1);
      ex_bad = (is_r | is_i) && (f3 == 3'd5);
      fl     = wf + 1;
      if (!dec_ok)           total = fl + 1;
      else if (is_r || is_i) total = ex_bad ? fl + 2 : fl + 3;
      else if (is_ld)        total = fl + wd + 4;
      else if (is_st)        total = fl + wd + 3;
      else if (is_br)        total = fl + 2;
      else                   total = fl + 3;

      for (int c = 0; c <= total; c++) begin
         rdy[c] = 1'($urandom_range(0, 1));
         zv[c]  = (zmode == 2) ? 1'($urandom_range(0, 1)) : (zmode == 1);
      end
      for (int c = 0; c < wf; c++) rdy[c] = 1'b0;
      rdy[wf] = 1'b1;
      if (is_ld || is_st) begin
         for (int c = 0; c < wd; c++) rdy[fl + 2 + c] = 1'b0;
         rdy[fl + 2 + wd] = 1'b1;
      end
      rdy[total] = 1'b0;

      op = o; funct3 = f3; funct7b5 = f7;
      for (int c = 0; c <= total; c++) begin
         mem_ready = rdy[c];
         zero      = zv[c];
         @(negedge clk);
         s_req[c] = mem_req;   s_mwr[c] = mem_write; s_adr[c] = adr_src;
         s_irw[c] = ir_write;  s_pcw[c] = pc_write;  s_rgw[c] = reg_write;
         s_ill[c] = illegal_instr;
         s_res[c] = result_src; s_sa[c] = alu_src_a; s_sb[c] = alu_src_b;
         s_imm[c] = imm_src;   s_alu[c] = alu_ctrl;
         @(posedge clk);
         #1;
      end

      n_req = 0; n_mwr = 0; n_irw = 0; n_pcw = 0; n_rgw = 0; n_ill = 0;
      for (int c = 0; c < total; c++) begin
         n_req += int'(s_req[c]); n_mwr += int'(s_mwr[c]); n_irw += int'(s_irw[c]);
         n_pcw += int'(s_pcw[c]); n_rgw += int'(s_rgw[c]); n_ill += int'(s_ill[c]);
      end

      exp_rw  = dec_ok && (((is_r || is_i) && !ex_bad) || is_ld || is_jal);
      exp_pcw = 1 + (is_jal ? 1 : 0) + ((is_br && dec_ok) ? int'(zv[fl + 1] ^ f3[0]) : 0);
      exp_imm = is_st ? 2'b01 : is_br ? 2'b10 : is_jal ? 2'b11 : 2'b00;

      check("ir_write_count",  32'(n_irw), 32'd1);
      check("reg_write_count", 32'(n_rgw), 32'(exp_rw));
      check("pc_write_count",  32'(n_pcw), 32'(exp_pcw));
      check("illegal_count",   32'(n_ill), 32'(!dec_ok || ex_bad));
      check("mem_req_cycles",  32'(n_req), 32'(fl + ((is_ld || is_st) ? wd + 1 : 0)));
      check("mem_write_cycles", 32'(n_mwr), 32'(is_st ? wd + 1 : 0));
      check("imm_src_decode",  32'(s_imm[fl]), 32'(exp_imm));
      if (dec_ok && (is_r || is_i) && !ex_bad) begin
         case (f3)
            3'd0:    exp_alu = (is_r && f7) ? 3'b001 : 3'b000;
            3'd1:    exp_alu = 3'b100;
            3'd2,
            3'd3:    exp_alu = 3'b101;
            3'd4:    exp_alu = 3'b110;
            3'd6:    exp_alu = 3'b011;
            default: exp_alu = 3'b010;
         endcase
         check("exec_alu_ctrl", 32'(s_alu[fl + 1]), 32'(exp_alu));
         check("exec_srcb", 32'(s_sb[fl + 1]), is_i ? 32'd1 : 32'd0);
      end
      if (is_br && dec_ok) check("branch_alu_ctrl", 32'(s_alu[fl + 1]), 32'd1);
      if (is_jal) check("jal_pc_write", 32'(s_pcw[fl + 1]), 32'd1);
      if (exp_rw) check("wb_result_src", 32'(s_res[total - 1]), is_ld ? 32'd1 : 32'd0);
      check("back_to_fetch", 32'({s_req[total], s_adr[total], s_sa[total], s_sb[total]}),
            32'({1'b1, 1'b0, 2'b00, 2'b10}));
   endtask

   initial begin
      mem_ready = 1'b1;
      repeat (2) @(negedge clk);
      check("reset_enables_low",
            32'({mem_req, mem_write, ir_write, pc_write, reg_write, illegal_instr}), 32'd0);
      @(posedge clk);
      #1 reset = 1'b0;
      mem_ready = 1'b0;
      @(negedge clk);
      check("first_fetch_req", 32'({mem_req, adr_src, ir_write}), 32'b100);
      @(posedge clk);
      #1;

      run_instr(7'h33, 3'd0, 1'b0, 0, 0, 2);   // add
      run_instr(7'h33, 3'd0, 1'b1, 0, 0, 2);   // sub
      run_instr(7'h13, 3'd0, 1'b1, 0, 0, 2);   // addi with instr[30] set
      run_instr(7'h03, 3'd2, 1'b0, 0, 3, 2);   // lw, 3 wait states
      run_instr(7'h23, 3'd2, 1'b0, 1, 2, 2);   // sw with waits
      run_instr(7'h63, 3'd0, 1'b0, 0, 0, 1);   // beq taken
      run_instr(7'h63, 3'd1, 1'b0, 0, 0, 1);   // bne not taken
      run_instr(7'h6F, 3'd0, 1'b0, 0, 0, 2);   // jal
      run_instr(7'h7F, 3'd0, 1'b0, 0, 0, 2);   // unsupported opcode
      run_instr(7'h13, 3'd5, 1'b0, 0, 0, 2);   // srli

      // Reset asserted while a store waits in MEMWRITE
      op = 7'h23; funct3 = 3'd2; funct7b5 = 1'b0;
      mem_ready = 1'b1;
      @(posedge clk); #1 mem_ready = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk);
      check("store_pending", 32'({mem_req, mem_write, adr_src}), 32'b111);
      #1 reset = 1'b1;
      #1;
      check("reset_mid_store_en", 32'({mem_req, mem_write, reg_write, pc_write}), 32'd0);
      check("reset_mid_store_fetch", 32'({adr_src, alu_src_b}), 32'({1'b0, 2'b10}));
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("refetch_after_reset", 32'({mem_req, adr_src, mem_write, reg_write}), 32'b1000);
      @(posedge clk);
      #1;

      for (int k = 0; k < 40; k++) begin
         logic [6:0] o;
         logic [6:0] bad_ops [7];
         bad_ops = '{7'h7F, 7'h37, 7'h17, 7'h67, 7'h73, 7'h0F, 7'h00};
         case ($urandom_range(0, 6))
            0:       o = 7'h33;
            1:       o = 7'h13;
            2:       o = 7'h03;
            3:       o = 7'h23;
            4:       o = 7'h63;
            5:       o = 7'h6F;
            default: o = bad_ops[$urandom_range(0, 6)];
         endcase
         run_instr(o, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 2);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/riscv_mc_controller.md
# riscv_mc_controller

Multicycle control FSM for the RV32I subset core. It drives the ALU's `alu_ctrl` encoding and operand selects, sequences register-file and memory writes, and consumes the ALU `zero` flag to resolve branches. It sits between the instruction register and the shared datapath, and talks to the unified instruction/data memory through a req/ready handshake.

## Interface
- No parameters; field widths are fixed by RV32I.
- `clk` input 1: rising-edge clock.
- `reset` input 1: asynchronous, active-high.
- `op` input 7: `instr[6:0]` from the instruction register.
- `funct3` input 3: `instr[14:12]`.
- `funct7b5` input 1: `instr[30]`.
- `zero` input 1: ALU zero flag.
- `mem_ready` input 1: memory completes the current access this cycle.
- `mem_req` output 1: memory access request.
- `mem_write` output 1: store strobe.
- `adr_src` output 1: 0 selects PC as address, 1 selects the ALU result register.
- `ir_write` output 1: latch the instruction register.
- `pc_write` output 1: PC update.
- `reg_write` output 1: register-file write.
- `result_src` output 2: 00 ALU result register, 01 memory data, 10 live ALU output.
- `alu_src_a` output 2: 00 PC, 01 old PC, 10 rs1.
- `alu_src_b` output 2: 00 rs2, 01 immediate, 10 constant 4.
- `imm_src` output 2: 00 I-type, 01 S-type, 10 B-type, 11 J-type.
- `alu_ctrl` output 3: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLL, 101 SLT, 110 XOR.
- `illegal_instr` output 1: one-cycle pulse on an unsupported encoding.

## Operation
- State register with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL.
- Outputs are combinational from state, `op`, `funct3`, `funct7b5` and `zero`, plus `mem_ready` where noted.
- Any signal not listed for a state is 0.
- **FETCH**
  - Outputs: `mem_req`=1, `adr_src`=0, `alu_src_a`=00, `alu_src_b`=10, ADD, `result_src`=10.
  - `ir_write` = `pc_write` = `mem_ready`.
  - Goes to DECODE on `mem_ready`; otherwise holds.
- **DECODE**
  - Outputs: `alu_src_a`=01, `alu_src_b`=01, ADD. This precomputes the branch/jump target.
  - `op` 0000011 or 0100011 → MEMADR.
  - `op` 0110011 → EXECR.
  - `op` 0010011 → EXECI.
  - `op` 1100011 with `funct3` 000/001 → BRANCH.
  - `op` 1101111 → JAL.
  - Any other encoding → FETCH with `illegal_instr`=1.
- **MEMADR**
  - Outputs: `alu_src_a`=10, `alu_src_b`=01, ADD.
  - Goes to MEMREAD if `op[5]`=0, otherwise MEMWRITE.
- **MEMREAD**
  - Outputs: `mem_req`=1, `adr_src`=1.
  - Goes to MEMWB on `mem_ready`; otherwise holds.
- **MEMWB**
  - Outputs: `result_src`=01, `reg_write`=1.
  - Goes to FETCH.
- **MEMWRITE**
  - Outputs: `mem_req`=1, `mem_write`=1, `adr_src`=1.
  - Goes to FETCH on `mem_ready`; otherwise holds with `mem_write` held high.
- **EXECR** and **EXECI**
  - Outputs: `alu_src_a`=10, `alu_src_b`=00 (EXECR) or 01 (EXECI).
  - Both go to ALUWB.
- **ALUWB**
  - Outputs: `result_src`=00, `reg_write`=1.
  - Goes to FETCH.
- **BRANCH**
  - Outputs: `alu_src_a`=10, `alu_src_b`=00, SUB, `result_src`=00.
  - `pc_write` = `zero` XOR `funct3[0]`, so BEQ is taken on equal and BNE on not-equal.
  - Goes to FETCH.
- **JAL**
  - Outputs: `alu_src_a`=01, `alu_src_b`=10, ADD, `result_src`=00, `pc_write`=1.
  - Goes to ALUWB, which writes PC+4 to rd.
- **ALU decode (EXECR/EXECI)**, by `funct3`:
  - 000: SUB only when R-type and `funct7b5`=1; ADD otherwise, so ADDI never subtracts.
  - 001 → SLL; 010/011 → SLT; 100 → XOR; 110 → OR; 111 → AND.
  - 101 (shift right) is illegal: pulse `illegal_instr` in the EXEC state, go to FETCH, no `reg_write`.
- **`imm_src`**, by `op`:
  - 0100011 → 01; 1100011 → 10; 1101111 → 11; all other values → 00.

## Timing
- **Reset**
  - `reset` high forces FETCH immediately, asynchronously.
  - While `reset` is high, all write enables, `mem_req` and `illegal_instr` are forced to 0.
  - The first FETCH request is issued in the cycle after `reset` deasserts.
- **Reset mid-access**
  - A pending MEMWRITE/MEMREAD is abandoned.
  - No `reg_write` or `pc_write` is generated for the abandoned access.
- **Handshake**
  - `mem_req` stays high until `mem_ready` is sampled high on a `clk` edge.
  - `mem_ready` while `mem_req`=0 is ignored.
  - `mem_ready` high in the same cycle as request entry completes the access in 1 cycle.
- **Latency with zero-wait memory**
  - R/I-type: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch: 3 cycles.
  - JAL: 4 cycles.
- **Wait states**
  - Each cycle of `mem_ready`=0 adds exactly 1 cycle to the affected state.
- **Single-cycle pulses**
  - `ir_write`, `reg_write` and `pc_write` are each high for at most 1 cycle per instruction.
  - Exception: FETCH's `pc_write` is followed by BRANCH/JAL's `pc_write` in the same instruction.

## Test plan
- **Reset mid-store**: assert `reset` in MEMWRITE → state FETCH same cycle, `mem_write`=0; after release, `mem_req`=1 with `adr_src`=0.
- **R-type**: `add` (0x002081B3), then `sub` (0x402081B3) with `mem_ready` tied 1 → `alu_ctrl` 000 and then 001 in EXECR; `reg_write`=1 in cycle 4 of each.
- **Load with wait states**: `lw` with `mem_ready` low for 3 cycles in MEMREAD → `mem_req` held 4 cycles; `reg_write` with `result_src`=01 exactly once.
- **Branches**: `beq` with `zero`=1 → `pc_write`=1 in BRANCH; `bne` with `zero`=1 → `pc_write`=0; `alu_ctrl`=001 in both.
- **JAL**: `jal` → `imm_src`=11, `pc_write` in JAL, then ALUWB `reg_write` with `result_src`=00.
- **Illegal encodings**: `op` 0x7F → `illegal_instr` pulse in DECODE, back to FETCH; `srli` → pulse in EXECI, no `reg_write`.
